// File: rtl/ula_ctrl_if.sv
// ula_ctrl_if: command and response handshake bundle for ula_ctrl.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : operation request (valid/ready)
//   rsp_valid/rsp_ready/rsp_result/rsp_overflow/rsp_error : result return (valid/ready)
// master = requester side, slave = ula_ctrl side.
interface ula_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_overflow;
  logic       rsp_error;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_overflow, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_overflow, rsp_error
  );
endinterface

// File: rtl/ula_ctrl.sv
// ula_ctrl: sequential front-end for an 8-bit combinational ALU.
//   clk, rst_n          : clock, asynchronous active-low reset
//   host (slave)        : command/response handshakes (see ula_ctrl_if)
//   alu_operator1/2     : ALU operand bus
//   alu_operation       : ALU opcode, zero-extended command opcode
//   alu_result/overflow : ALU outputs, sampled at the end of the settle window
//   busy                : high whenever not idle
//   op_count            : completed response handshakes (wraps)
// Divide-by-zero and illegal opcodes are answered locally without touching the ALU bus.
module ula_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ula_ctrl_if.slave          host,
  output logic [7:0]         alu_operator1,
  output logic [7:0]         alu_operator2,
  output logic [7:0]         alu_operation,
  input  logic [7:0]         alu_result,
  input  logic               alu_overflow,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, PREP, DRIVE, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] a_q;
  logic [3:0] cnt_q;
  logic [7:0] result_q;
  logic       overflow_q;
  logic       error_q;
  logic       accept;
  logic       trap_illegal;
  logic       trap_div0;

  assign accept       = (state_q == IDLE) && host.cmd_valid;
  assign trap_illegal = (host.cmd_op[2:1] == 2'b11);
  assign trap_div0    = (host.cmd_op == 3'd5) && (host.cmd_b == 8'd0);

  assign host.cmd_ready    = (state_q == IDLE);
  assign host.rsp_valid    = (state_q == RESP);
  assign host.rsp_result   = result_q;
  assign host.rsp_overflow = overflow_q;
  assign host.rsp_error    = error_q;
  assign busy              = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host.cmd_valid) state_d = (trap_illegal || trap_div0) ? RESP : PREP;
      PREP:    state_d = DRIVE;
      DRIVE:   if (cnt_q == '0) state_d = RESP;
      RESP:    if (host.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The ALU bus is registered so it naturally holds across IDLE/RESP.
  // PREP drives ~a first so DRIVE always presents a changed operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      overflow_q    <= 1'b0;
      error_q       <= 1'b0;
      alu_operator1 <= '0;
      alu_operator2 <= '0;
      alu_operation <= '0;
      op_count      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q <= host.cmd_a;
            if (trap_illegal) begin
              result_q   <= 8'h00;
              error_q    <= 1'b1;
              overflow_q <= 1'b0;
            end else if (trap_div0) begin
              result_q   <= 8'hFF;
              error_q    <= 1'b1;
              overflow_q <= 1'b0;
            end else begin
              alu_operation <= {5'b0, host.cmd_op};
              alu_operator1 <= ~host.cmd_a;
              alu_operator2 <= host.cmd_b;
            end
          end
        end
        PREP: begin
          alu_operator1 <= a_q;
          cnt_q         <= SETTLE_LOAD;
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            result_q   <= alu_result;
            overflow_q <= alu_overflow;
            error_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (host.rsp_ready) op_count <= op_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: directed self-checking bench for ula_ctrl with a behavioural ALU.
// u0 uses default parameters; u1 uses COUNT_W=2 for the counter wrap check.
module tb_ula_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_ctrl_if if0 ();
  ula_ctrl_if if1 ();

  logic [7:0]  op1_0, op2_0, opr_0, res_0;
  logic        ovf_0, busy_0;
  logic [15:0] cnt_0;
  logic [7:0]  op1_1, op2_1, opr_1;
  logic        busy_1;
  logic [1:0]  cnt_1;

  ula_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .host(if0),
    .alu_operator1(op1_0), .alu_operator2(op2_0), .alu_operation(opr_0),
    .alu_result(res_0), .alu_overflow(ovf_0),
    .busy(busy_0), .op_count(cnt_0)
  );

  ula_ctrl #(.COUNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .host(if1),
    .alu_operator1(op1_1), .alu_operator2(op2_1), .alu_operation(opr_1),
    .alu_result(8'h00), .alu_overflow(1'b0),
    .busy(busy_1), .op_count(cnt_1)
  );

  // Reference ALU: carry/borrow/upper-product flags as overflow.
  logic [8:0]  w9;
  logic [15:0] w16;
  always_comb begin
    w9 = '0; w16 = '0; res_0 = '0; ovf_0 = 1'b0;
    case (opr_0[2:0])
      3'd0: begin w9 = {1'b0, op1_0} + {1'b0, op2_0}; res_0 = w9[7:0]; ovf_0 = w9[8]; end
      3'd1: begin res_0 = op1_0 - op2_0; ovf_0 = (op1_0 < op2_0); end
      3'd2: res_0 = op1_0 & op2_0;
      3'd3: res_0 = op1_0 | op2_0;
      3'd4: begin w16 = op1_0 * op2_0; res_0 = w16[7:0]; ovf_0 = (w16[15:8] != 0); end
      3'd5: res_0 = (op2_0 != 0) ? op1_0 / op2_0 : 8'h00;
      default: res_0 = 8'h00;
    endcase
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accept edge (PREP, or RESP when trapped).
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!if0.cmd_ready && n < 20) begin tick(); n++; end
    chk("send_ready", {15'b0, if0.cmd_ready}, 16'd1);
    if0.cmd_op = op; if0.cmd_a = a; if0.cmd_b = b; if0.cmd_valid = 1'b1;
    tick();
    if0.cmd_valid = 1'b0;
  endtask

  // Latency counted from the accept edge.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!if0.rsp_valid && lat < 20) begin tick(); lat++; end
  endtask

  int lat;

  initial begin
    if0.cmd_valid = 0; if0.cmd_op = 0; if0.cmd_a = 0; if0.cmd_b = 0; if0.rsp_ready = 0;
    if1.cmd_valid = 0; if1.cmd_op = 0; if1.cmd_a = 0; if1.cmd_b = 0; if1.rsp_ready = 0;
    tick(); tick();
    chk("rst_cmd_ready", {15'b0, if0.cmd_ready}, 16'd1);
    chk("rst_busy", {15'b0, busy_0}, 16'd0);
    chk("rst_rsp_valid", {15'b0, if0.rsp_valid}, 16'd0);
    chk("rst_rsp_result", {8'b0, if0.rsp_result}, 16'd0);
    chk("rst_op_count", cnt_0, 16'd0);
    chk("rst_alu_op1", {8'b0, op1_0}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Add with overflow
    if0.rsp_ready = 1'b1;
    send(3'd0, 8'd200, 8'd100);
    wait_rsp(lat);
    chk("add_latency", 16'(lat), 16'd3);
    chk("add_result", {8'b0, if0.rsp_result}, 16'd44);
    chk("add_overflow", {15'b0, if0.rsp_overflow}, 16'd1);
    chk("add_error", {15'b0, if0.rsp_error}, 16'd0);
    tick();
    chk("add_count", cnt_0, 16'd1);

    // Same operands, new opcode
    send(3'd2, 8'd12, 8'd10);
    chk("and_prep_op1", {8'b0, op1_0}, 16'h00F3);
    chk("and_prep_op2", {8'b0, op2_0}, 16'd10);
    chk("and_prep_opr", {8'b0, opr_0}, 16'd2);
    wait_rsp(lat);
    chk("and_result", {8'b0, if0.rsp_result}, 16'd8);
    tick();
    send(3'd3, 8'd12, 8'd10);
    chk("or_prep_op1", {8'b0, op1_0}, 16'h00F3);
    tick();
    chk("or_drive_op1", {8'b0, op1_0}, 16'd12);
    wait_rsp(lat);
    chk("or_result", {8'b0, if0.rsp_result}, 16'd14);
    chk("or_overflow", {15'b0, if0.rsp_overflow}, 16'd0);
    tick();

    // Divide by zero: trapped, ALU bus untouched
    send(3'd5, 8'd10, 8'd0);
    wait_rsp(lat);
    chk("div0_latency", 16'(lat), 16'd1);
    chk("div0_result", {8'b0, if0.rsp_result}, 16'h00FF);
    chk("div0_error", {15'b0, if0.rsp_error}, 16'd1);
    chk("div0_overflow", {15'b0, if0.rsp_overflow}, 16'd0);
    chk("div0_bus_op1", {8'b0, op1_0}, 16'd12);
    chk("div0_bus_op2", {8'b0, op2_0}, 16'd10);
    chk("div0_bus_opr", {8'b0, opr_0}, 16'd3);
    tick();
    chk("div0_count", cnt_0, 16'd4);

    // Illegal opcode
    send(3'd6, 8'd33, 8'd44);
    wait_rsp(lat);
    chk("ill_latency", 16'(lat), 16'd1);
    chk("ill_result", {8'b0, if0.rsp_result}, 16'd0);
    chk("ill_error", {15'b0, if0.rsp_error}, 16'd1);
    chk("ill_overflow", {15'b0, if0.rsp_overflow}, 16'd0);
    tick();

    // Legal divide
    send(3'd5, 8'd100, 8'd7);
    wait_rsp(lat);
    chk("div_result", {8'b0, if0.rsp_result}, 16'd14);
    chk("div_error", {15'b0, if0.rsp_error}, 16'd0);
    tick();

    // Backpressure
    if0.rsp_ready = 1'b0;
    send(3'd1, 8'd5, 8'd3);
    wait_rsp(lat);
    chk("bp_latency", 16'(lat), 16'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {15'b0, if0.rsp_valid}, 16'd1);
      chk("bp_result", {8'b0, if0.rsp_result}, 16'd2);
      chk("bp_cmd_ready", {15'b0, if0.cmd_ready}, 16'd0);
      chk("bp_busy", {15'b0, busy_0}, 16'd1);
      tick();
    end
    if0.rsp_ready = 1'b1;
    tick();
    chk("bp_idle_ready", {15'b0, if0.cmd_ready}, 16'd1);
    chk("bp_idle_busy", {15'b0, busy_0}, 16'd0);
    chk("bp_count", cnt_0, 16'd7);

    // Reset during DRIVE
    send(3'd4, 8'd16, 8'd16);
    tick();
    chk("mul_drive_op1", {8'b0, op1_0}, 16'd16);
    chk("mul_drive_busy", {15'b0, busy_0}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", {15'b0, busy_0}, 16'd0);
    chk("mr_cmd_ready", {15'b0, if0.cmd_ready}, 16'd1);
    chk("mr_count", cnt_0, 16'd0);
    chk("mr_result", {8'b0, if0.rsp_result}, 16'd0);
    chk("mr_op1", {8'b0, op1_0}, 16'd0);
    chk("mr_opr", {8'b0, opr_0}, 16'd0);
    tick(); tick();
    chk("mr_rsp_valid", {15'b0, if0.rsp_valid}, 16'd0);
    rst_n = 1'b1;
    tick();
    send(3'd0, 8'd1, 8'd2);
    wait_rsp(lat);
    chk("post_rst_result", {8'b0, if0.rsp_result}, 16'd3);
    tick();
    chk("post_rst_count", cnt_0, 16'd1);

    // Counter wrap with COUNT_W=2, trapped ops back to back
    if1.rsp_ready = 1'b1;
    if1.cmd_op = 3'd7;
    if1.cmd_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      int n = 0;
      logic [1:0] expk;
      expk = 2'(k);
      while (!if1.rsp_valid && n < 10) begin tick(); n++; end
      chk("wrap_valid", {15'b0, if1.rsp_valid}, 16'd1);
      tick();
      chk("wrap_count", {14'b0, cnt_1}, {14'b0, expk});
    end
    if1.cmd_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
